// File: rtl/blit_pkg.sv
// Shared geometry, bus widths, FSM state type and sprite address helper for the sprite blitter.
package blit_pkg;

   localparam int SCREEN_W        = 640;
   localparam int SCREEN_H        = 480;
   localparam int SPRITE_W        = 50;
   localparam int SPRITE_H        = 50;
   localparam int IDX_W           = 9;
   localparam int SPR_ADDR_W      = 13;
   localparam int FB_ADDR_W       = 20;
   localparam int TRANSPARENT_IDX = 0;

   localparam int COL_W      = $clog2(SPRITE_W);
   localparam int ROW_W      = $clog2(SPRITE_H);
   localparam int X_W        = 11;
   localparam int Y_W        = 10;
   localparam int SPR_PIXELS = SPRITE_W * SPRITE_H;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } blit_state_t;

   // A mirrored sprite reads each row right-to-left while being placed left-to-right.
   function automatic logic [SPR_ADDR_W-1:0] spriteAddr(input logic [ROW_W-1:0] row,
                                                        input logic [COL_W-1:0] col,
                                                        input logic           mirror);
      logic [COL_W-1:0] srcCol;
      srcCol = mirror ? (COL_W'(SPRITE_W - 1) - col) : col;
      return (SPR_ADDR_W'(row) * SPR_ADDR_W'(SPRITE_W)) + SPR_ADDR_W'(srcCol);
   endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// Game-logic handshake, sprite ROM read port and framebuffer write port of the sprite blitter.
// The mirror request only exists when SPRITE_BLITTER_MIRROR_EN is defined.
interface sprite_blitter_if;
   import blit_pkg::*;

   logic                  start;
   logic [9:0]            x0;
   logic [8:0]            y0;
`ifdef SPRITE_BLITTER_MIRROR_EN
   logic                  mirror;
`endif
   logic                  busy;
   logic                  done;
   logic [SPR_ADDR_W-1:0] spr_addr;
   logic [IDX_W-1:0]      spr_data;
   logic [FB_ADDR_W-1:0]  fb_addr;
   logic [IDX_W-1:0]      fb_data;
   logic                  fb_wEn;

   modport master (
`ifdef SPRITE_BLITTER_MIRROR_EN
      output mirror,
`endif
      output start, x0, y0, spr_data,
      input  busy, done, spr_addr, fb_addr, fb_data, fb_wEn
   );

   modport slave (
`ifdef SPRITE_BLITTER_MIRROR_EN
      input  mirror,
`endif
      input  start, x0, y0, spr_data,
      output busy, done, spr_addr, fb_addr, fb_data, fb_wEn
   );

endinterface

// File: rtl/blit_raster_counter.sv
// Raster-order col/row walker over the sprite, producing the registered sprite ROM address.
module blit_raster_counter
   import blit_pkg::*;
(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clear_i,
   input  logic                  advance_i,
   input  logic                  mirror_i,
   output logic [COL_W-1:0]      col_o,
   output logic [ROW_W-1:0]      row_o,
   output logic                  last_o,
   output logic [SPR_ADDR_W-1:0] addr_o
);

   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   logic [SPR_ADDR_W-1:0] addr_q, addr_d;

   assign last_o = (row_q == ROW_W'(SPRITE_H - 1)) && (col_q == COL_W'(SPRITE_W - 1));

   // The walker parks on the last pixel rather than wrapping; the caller decides when to stop.
   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      addr_d = addr_q;
      if (clear_i) begin
         col_d  = '0;
         row_d  = '0;
         addr_d = spriteAddr('0, '0, mirror_i);
      end else if (advance_i && !last_o) begin
         if (col_q == COL_W'(SPRITE_W - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
         addr_d = spriteAddr(row_d, col_d, mirror_i);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col_q  <= '0;
         row_q  <= '0;
         addr_q <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         addr_q <= addr_d;
      end
   end

   assign col_o  = col_q;
   assign row_o  = row_q;
   assign addr_o = addr_q;

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from the sprite ROM into the framebuffer at a clipped screen origin.
// Horizontal mirroring is built in only when SPRITE_BLITTER_MIRROR_EN is defined.
module sprite_blitter
   import blit_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   sprite_blitter_if.slave bus
);

   blit_state_t state_q, state_d;
   logic        drainCnt_q;

   logic [9:0] x0_q;
   logic [8:0] y0_q;
   logic       mirror_q;
   logic       mirrorIn;

   logic accept;
   logic advance;
   logic busy;
   logic done;

   logic [COL_W-1:0]      col;
   logic [ROW_W-1:0]      row;
   logic                  last;
   logic [SPR_ADDR_W-1:0] sprAddr;

   logic [X_W-1:0] xSum, s1XSum;
   logic [Y_W-1:0] ySum, s1YSum;

   logic             s1Valid_q, s1Last_q, s1InBounds_q;
   logic [COL_W-1:0] s1Col_q;
   logic [ROW_W-1:0] s1Row_q;

   logic [FB_ADDR_W-1:0] fbAddr_q, fbAddr_d;
   logic [IDX_W-1:0]     fbData_q, fbData_d;
   logic                 fbWEn_q, fbWEn_d;

`ifdef SPRITE_BLITTER_MIRROR_EN
   assign mirrorIn = bus.mirror;
`else
   assign mirrorIn = 1'b0;
`endif

   assign accept = (state_q == IDLE) && bus.start;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         drainCnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         drainCnt_q <= (state_q == DRAIN) && !drainCnt_q;
      end
   end

   // READ ends one cycle after the last address enters the pipe, so its flags are already in flight.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = READ;
         READ:    if (s1Last_q)  state_d = DRAIN;
         DRAIN:   if (drainCnt_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q == READ) || (state_q == DRAIN);
      done    = (state_q == DONE);
      advance = (state_q == READ) && !s1Last_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x0_q     <= '0;
         y0_q     <= '0;
         mirror_q <= 1'b0;
      end else if (accept) begin
         x0_q     <= bus.x0;
         y0_q     <= bus.y0;
         mirror_q <= mirrorIn;
      end
   end

   blit_raster_counter u_counter (
      .clk       (clk),
      .resetn    (resetn),
      .clear_i   (accept),
      .advance_i (advance),
      .mirror_i  (accept ? mirrorIn : mirror_q),
      .col_o     (col),
      .row_o     (row),
      .last_o    (last),
      .addr_o    (sprAddr)
   );

   // Sums are one bit wider than the screen coordinates so off-screen pixels clip instead of wrapping.
   assign xSum = {1'b0, x0_q} + X_W'(col);
   assign ySum = {1'b0, y0_q} + Y_W'(row);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1Valid_q    <= 1'b0;
         s1Last_q     <= 1'b0;
         s1InBounds_q <= 1'b0;
         s1Col_q      <= '0;
         s1Row_q      <= '0;
      end else begin
         s1Valid_q <= advance;
         s1Last_q  <= advance && last;
         if (advance) begin
            s1Col_q      <= col;
            s1Row_q      <= row;
            s1InBounds_q <= (xSum < X_W'(SCREEN_W)) && (ySum < Y_W'(SCREEN_H));
         end
      end
   end

   assign s1XSum = {1'b0, x0_q} + X_W'(s1Col_q);
   assign s1YSum = {1'b0, y0_q} + Y_W'(s1Row_q);

   always_comb begin
      fbAddr_d = fbAddr_q;
      fbData_d = fbData_q;
      fbWEn_d  = s1Valid_q && s1InBounds_q && (bus.spr_data != IDX_W'(TRANSPARENT_IDX));
      if (s1Valid_q && s1InBounds_q) begin
         fbAddr_d = (FB_ADDR_W'(s1YSum) * FB_ADDR_W'(SCREEN_W)) + FB_ADDR_W'(s1XSum);
         fbData_d = bus.spr_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fbAddr_q <= '0;
         fbData_q <= '0;
         fbWEn_q  <= 1'b0;
      end else begin
         fbAddr_q <= fbAddr_d;
         fbData_q <= fbData_d;
         fbWEn_q  <= fbWEn_d;
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.spr_addr = sprAddr;
   assign bus.fb_addr  = fbAddr_q;
   assign bus.fb_data  = fbData_q;
   assign bus.fb_wEn   = fbWEn_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: ROM model plus write/done/busy observation per blit.
// The mirror scenario is compiled in when SPRITE_BLITTER_MIRROR_EN is defined.
module tb_sprite_blitter;
   import blit_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   int   cyc = 0;

   int vectors     = 0;
   int miscompares = 0;

   logic [IDX_W-1:0] rom [SPR_PIXELS];

   int startCyc, wrCount, firstCyc, firstAddr, firstData, lastAddr, lastData;
   int doneCount, doneCyc, busyCount, oobCount, badPlace, fbAt0, fbAt49;

   sprite_blitter_if bus ();

   sprite_blitter dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous sprite ROM: data for the address seen at an edge appears after that edge.
   always @(posedge clk)
      bus.spr_data <= (int'(bus.spr_addr) < SPR_PIXELS) ? rom[bus.spr_addr] : '0;

   task automatic fillRomPattern();
      for (int a = 0; a < SPR_PIXELS; a++) rom[a] = IDX_W'((a % 255) + 1);
   endtask

   // Starts one blit, then observes every cycle until two cycles after done or the budget expires.
   task automatic applyStimulus(input int x, input int y, input logic mir, input int pokeAt, input int budget);
      int fx, fy, a;
      wrCount = 0; firstCyc = -1; firstAddr = -1; firstData = -1; lastAddr = -1; lastData = -1;
      doneCount = 0; doneCyc = -1; busyCount = 0; oobCount = 0; badPlace = 0; fbAt0 = -1; fbAt49 = -1;
      @(negedge clk);
      bus.x0 = 10'(x);
      bus.y0 = 9'(y);
`ifdef SPRITE_BLITTER_MIRROR_EN
      bus.mirror = mir;
`else
      if (mir) $display("[TB] mirror requested but not built in");
`endif
      bus.start = 1'b1;
      @(negedge clk);
      startCyc  = cyc;
      bus.start = 1'b0;
      bus.x0    = 10'(x) ^ 10'h155;
      bus.y0    = 9'(y) ^ 9'h0AA;
      for (int k = 0; k < budget; k++) begin
         if (bus.busy) busyCount++;
         if (bus.fb_wEn) begin
            a  = int'(bus.fb_addr);
            fx = a % SCREEN_W;
            fy = a / SCREEN_W;
            wrCount++;
            if (firstCyc < 0) begin
               firstCyc  = cyc;
               firstAddr = a;
               firstData = int'(bus.fb_data);
            end
            lastAddr = a;
            lastData = int'(bus.fb_data);
            if (a >= SCREEN_W * SCREEN_H) oobCount++;
            if (fx < x || fx >= x + SPRITE_W || fy < y || fy >= y + SPRITE_H) badPlace++;
            if (a == 0)  fbAt0  = int'(bus.fb_data);
            if (a == 49) fbAt49 = int'(bus.fb_data);
         end
         if (bus.done) begin
            doneCount++;
            doneCyc = cyc;
         end
         if (doneCyc >= 0 && cyc >= doneCyc + 2) break;
         bus.start = (pokeAt > 0) && (cyc == startCyc + pokeAt - 1);
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b, expected 0", bus.done); end
      vectors++; if (bus.fb_wEn !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wEn: got %b, expected 0", bus.fb_wEn); end
      vectors++; if (bus.spr_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_spr_addr: got %0d, expected 0", bus.spr_addr); end
      vectors++; if (bus.fb_addr !== '0) begin miscompares++; $display("[TB] FAIL reset_fb_addr: got %0d, expected 0", bus.fb_addr); end
      vectors++; if (bus.fb_data !== '0) begin miscompares++; $display("[TB] FAIL reset_fb_data: got %0d, expected 0", bus.fb_data); end
      resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_origin();
      fillRomPattern();
      applyStimulus(100, 50, 1'b0, 0, 2700);
      vectors++; if (wrCount !== 2500) begin miscompares++; $display("[TB] FAIL origin_writes: got %0d, expected 2500", wrCount); end
      vectors++; if (firstAddr !== 32100) begin miscompares++; $display("[TB] FAIL origin_first_addr: got %0d, expected 32100", firstAddr); end
      vectors++; if (firstData !== 1) begin miscompares++; $display("[TB] FAIL origin_first_data: got %0d, expected 1", firstData); end
      vectors++; if (firstCyc !== startCyc + 2) begin miscompares++; $display("[TB] FAIL origin_first_cycle: got E+%0d, expected E+2", firstCyc - startCyc); end
      vectors++; if (lastAddr !== 63509) begin miscompares++; $display("[TB] FAIL origin_last_addr: got %0d, expected 63509", lastAddr); end
      vectors++; if (lastData !== 205) begin miscompares++; $display("[TB] FAIL origin_last_data: got %0d, expected 205", lastData); end
      vectors++; if (doneCount !== 1) begin miscompares++; $display("[TB] FAIL origin_done_count: got %0d, expected 1", doneCount); end
      vectors++; if (doneCyc !== startCyc + 2503) begin miscompares++; $display("[TB] FAIL origin_done_cycle: got E+%0d, expected E+2503", doneCyc - startCyc); end
      vectors++; if (busyCount !== 2503) begin miscompares++; $display("[TB] FAIL origin_busy_cycles: got %0d, expected 2503", busyCount); end
      vectors++; if (badPlace !== 0) begin miscompares++; $display("[TB] FAIL origin_placement: got %0d misplaced, expected 0", badPlace); end
   endtask

   task automatic test_transparency();
      for (int a = 0; a < SPR_PIXELS; a++) rom[a] = '0;
      rom[0]    = 9'd7;
      rom[2499] = 9'd9;
      applyStimulus(100, 50, 1'b0, 0, 2700);
      vectors++; if (wrCount !== 2) begin miscompares++; $display("[TB] FAIL transp_writes: got %0d, expected 2", wrCount); end
      vectors++; if (firstAddr !== 32100 || firstData !== 7) begin miscompares++; $display("[TB] FAIL transp_first: got %0d/%0d, expected 32100/7", firstAddr, firstData); end
      vectors++; if (lastAddr !== 63509 || lastData !== 9) begin miscompares++; $display("[TB] FAIL transp_last: got %0d/%0d, expected 63509/9", lastAddr, lastData); end
      vectors++; if (doneCount !== 1) begin miscompares++; $display("[TB] FAIL transp_done_count: got %0d, expected 1", doneCount); end
   endtask

   task automatic test_clipping();
      fillRomPattern();
      applyStimulus(620, 470, 1'b0, 0, 2700);
      vectors++; if (wrCount !== 200) begin miscompares++; $display("[TB] FAIL clip_writes: got %0d, expected 200", wrCount); end
      vectors++; if (oobCount !== 0) begin miscompares++; $display("[TB] FAIL clip_out_of_range: got %0d, expected 0", oobCount); end
      vectors++; if (badPlace !== 0) begin miscompares++; $display("[TB] FAIL clip_placement: got %0d misplaced, expected 0", badPlace); end
      vectors++; if (firstAddr !== 301420 || firstData !== 1) begin miscompares++; $display("[TB] FAIL clip_first: got %0d/%0d, expected 301420/1", firstAddr, firstData); end
      vectors++; if (lastAddr !== 307199 || lastData !== 215) begin miscompares++; $display("[TB] FAIL clip_last: got %0d/%0d, expected 307199/215", lastAddr, lastData); end
      vectors++; if (doneCount !== 1 || doneCyc !== startCyc + 2503) begin miscompares++; $display("[TB] FAIL clip_done: got %0d pulses at E+%0d, expected 1 at E+2503", doneCount, doneCyc - startCyc); end
   endtask

   task automatic test_offscreen();
      fillRomPattern();
      applyStimulus(640, 0, 1'b0, 0, 2700);
      vectors++; if (wrCount !== 0) begin miscompares++; $display("[TB] FAIL offscreen_writes: got %0d, expected 0", wrCount); end
      vectors++; if (doneCount !== 1 || doneCyc !== startCyc + 2503) begin miscompares++; $display("[TB] FAIL offscreen_done: got %0d pulses at E+%0d, expected 1 at E+2503", doneCount, doneCyc - startCyc); end
   endtask

   task automatic test_start_while_busy();
      fillRomPattern();
      applyStimulus(100, 50, 1'b0, 100, 2700);
      vectors++; if (doneCount !== 1) begin miscompares++; $display("[TB] FAIL busy_start_done_count: got %0d, expected 1", doneCount); end
      vectors++; if (doneCyc !== startCyc + 2503) begin miscompares++; $display("[TB] FAIL busy_start_done_cycle: got E+%0d, expected E+2503", doneCyc - startCyc); end
      vectors++; if (busyCount !== 2503) begin miscompares++; $display("[TB] FAIL busy_start_busy_cycles: got %0d, expected 2503", busyCount); end
      vectors++; if (wrCount !== 2500) begin miscompares++; $display("[TB] FAIL busy_start_writes: got %0d, expected 2500", wrCount); end
   endtask

   task automatic test_reset_mid_blit();
      int strayWrites;
      fillRomPattern();
      applyStimulus(100, 50, 1'b0, 0, 1000);
      vectors++; if (bus.fb_wEn !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_pre_wEn: got %b, expected 1", bus.fb_wEn); end
      #1 resetn = 1'b0;
      #1;
      vectors++; if (bus.fb_wEn !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_wEn: got %b, expected 0", bus.fb_wEn); end
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_busy: got %b, expected 0", bus.busy); end
      strayWrites = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.fb_wEn !== 1'b0) strayWrites++;
      end
      vectors++; if (strayWrites !== 0) begin miscompares++; $display("[TB] FAIL midreset_stray_writes: got %0d, expected 0", strayWrites); end
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus(100, 50, 1'b0, 0, 2700);
      vectors++; if (wrCount !== 2500) begin miscompares++; $display("[TB] FAIL midreset_rerun_writes: got %0d, expected 2500", wrCount); end
      vectors++; if (lastAddr !== 63509 || lastData !== 205) begin miscompares++; $display("[TB] FAIL midreset_rerun_last: got %0d/%0d, expected 63509/205", lastAddr, lastData); end
      vectors++; if (doneCount !== 1 || doneCyc !== startCyc + 2503) begin miscompares++; $display("[TB] FAIL midreset_rerun_done: got %0d pulses at E+%0d, expected 1 at E+2503", doneCount, doneCyc - startCyc); end
   endtask

   task automatic test_back_to_back();
      int s, d1, d2, gapIdle, gapBusy;
      fillRomPattern();
      d1 = -1; d2 = -1; gapIdle = -1; gapBusy = -1;
      @(negedge clk);
      bus.x0    = 10'd100;
      bus.y0    = 9'd50;
      bus.start = 1'b1;
      @(negedge clk);
      s = cyc;
      for (int k = 0; k < 5300; k++) begin
         if (d1 >= 0 && cyc == d1 + 1) gapIdle = int'(bus.busy);
         if (d1 >= 0 && cyc == d1 + 2) gapBusy = int'(bus.busy);
         if (bus.done) begin
            if (d1 < 0) d1 = cyc;
            else d2 = cyc;
         end
         if (d2 >= 0) break;
         @(negedge clk);
      end
      bus.start = 1'b0;
      vectors++; if (d1 !== s + 2503) begin miscompares++; $display("[TB] FAIL b2b_first_done: got E+%0d, expected E+2503", d1 - s); end
      vectors++; if (gapIdle !== 0 || gapBusy !== 1) begin miscompares++; $display("[TB] FAIL b2b_idle_gap: got busy %0d then %0d, expected 0 then 1", gapIdle, gapBusy); end
      vectors++; if (d2 !== s + 5008) begin miscompares++; $display("[TB] FAIL b2b_second_done: got E+%0d, expected E+5008", d2 - s); end
      repeat (4) @(negedge clk);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_stops: got busy %b, expected 0", bus.busy); end
   endtask

`ifdef SPRITE_BLITTER_MIRROR_EN
   task automatic test_mirror();
      fillRomPattern();
      applyStimulus(0, 0, 1'b1, 0, 2700);
      vectors++; if (fbAt0 !== 50) begin miscompares++; $display("[TB] FAIL mirror_fb0: got %0d, expected 50", fbAt0); end
      vectors++; if (fbAt49 !== 1) begin miscompares++; $display("[TB] FAIL mirror_fb49: got %0d, expected 1", fbAt49); end
      vectors++; if (wrCount !== 2500) begin miscompares++; $display("[TB] FAIL mirror_writes: got %0d, expected 2500", wrCount); end
   endtask
`endif

   initial begin
      resetn       = 1'b0;
      bus.start    = 1'b0;
      bus.x0       = '0;
      bus.y0       = '0;
`ifdef SPRITE_BLITTER_MIRROR_EN
      bus.mirror   = 1'b0;
`endif
      bus.spr_data = '0;
      test_reset();
      test_origin();
      test_transparency();
      test_clipping();
      test_offscreen();
      test_start_while_busy();
      test_reset_mid_blit();
      test_back_to_back();
`ifdef SPRITE_BLITTER_MIRROR_EN
      test_mirror();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Writer side of the sprite image memories: copies one SPRITE_W x SPRITE_H sprite of palette indices from a sprite ROM into the full-screen palette-index framebuffer RAM.
- The copy is placed at screen origin (x0, y0), with clipping and a transparent index.
- Sits between the game logic (start/done handshake) and the framebuffer RAM write port; the VGA path reads the same framebuffer through the palette.

Parameters:
- SCREEN_W, 640: framebuffer width in pixels.
- SCREEN_H, 480: framebuffer height in pixels.
- SPRITE_W, 50: sprite width.
- SPRITE_H, 50: sprite height.
- IDX_W, 9: palette index width, $clog2(256)+1.
- SPR_ADDR_W, 13: sprite ROM address width, $clog2(SPRITE_W*SPRITE_H)+1.
- FB_ADDR_W, 20: framebuffer address width, $clog2(SCREEN_W*SCREEN_H)+1.
- TRANSPARENT_IDX, 0: source index that is never written.

Ports:
- clk  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request a blit; sampled only in IDLE.
- x0  input  10  sprite left column on screen.
- y0  input  9  sprite top row on screen.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse at blit completion.
- spr_addr  output  SPR_ADDR_W  sprite ROM read address, registered.
- spr_data  input  IDX_W  sprite ROM data; synchronous ROM, valid 1 cycle after spr_addr.
- fb_addr  output  FB_ADDR_W  framebuffer write address, registered.
- fb_data  output  IDX_W  framebuffer write data, registered.
- fb_wEn  output  1  framebuffer write enable, registered.

Behaviour:
- Reset (asynchronous, active-low, immediate):
  - State is IDLE.
  - busy=0, done=0, fb_wEn=0.
  - spr_addr=0, fb_addr=0, fb_data=0.
  - Row/column counters are 0.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On start=1, latch x0/y0, clear col/row, set busy=1, go to READ.
  - Latched origin is frozen for the whole blit; later x0/y0 changes are ignored.
- READ:
  - Each cycle present spr_addr = row*SPRITE_W + col.
  - Raster order, col fastest; col wraps at SPRITE_W-1 with row+1.
  - After issuing address SPRITE_W*SPRITE_H-1, go to DRAIN.
- Write pipeline:
  - Row/col/in-bounds flags of each issued address are delayed 1 cycle to align with spr_data.
  - On the next edge, register fb_addr = (y0+row)*SCREEN_W + (x0+col) and fb_data = spr_data.
  - fb_wEn=1 only if x0+col < SCREEN_W, y0+row < SCREEN_H and spr_data != TRANSPARENT_IDX.
  - Sums are computed at 11 bits (x) and 10 bits (y) so they do not wrap; off-screen pixels are clipped, never wrapped.
- DRAIN: two cycles letting the final ROM read and write retire; no new addresses.
- DONE:
  - done=1 for exactly one cycle; busy falls in the same cycle; return to IDLE.
- Timing:
  - Start accepted at edge E; busy is high from E through E + SPRITE_W*SPRITE_H + 2.
  - First possible fb_wEn at E+2.
  - done pulses at E + SPRITE_W*SPRITE_H + 3.
- start while busy or in DONE is ignored; there is no queueing.
- start held high continuously gives back-to-back blits, with one IDLE cycle between them.
- A fully off-screen origin (x0>=SCREEN_W) still runs the full sequence with zero writes, and done still pulses.
- Reset mid-blit aborts with no further writes; a partially drawn sprite is acceptable.

Optional Feature:
- Macro SPRITE_BLITTER_MIRROR_EN.
- When defined:
  - Extra input port mirror (1 bit), latched with start.
  - When the latched mirror=1, spr_addr = row*SPRITE_W + (SPRITE_W-1-col).
  - Screen placement is unchanged, so the sprite is drawn horizontally flipped.
- When undefined: the port is absent and behaviour is as above.

Decomposition:
- Package blit_pkg holds:
  - SCREEN_W, SCREEN_H, SPRITE_W, SPRITE_H, IDX_W, SPR_ADDR_W, FB_ADDR_W, TRANSPARENT_IDX defaults.
  - State enum type blit_state_t.
- One sub-module, blit_raster_counter:
  - col/row counter with clear, advance, last-pixel flag and linear sprite address output.
  - Also used by the FSM for termination.

Test Plan:
- Origin test:
  - Stimulus: ROM pattern idx = (addr%255)+1, x0=100, y0=50, start pulse.
  - Response: exactly 2500 writes; first fb_addr=32100, fb_data=1; last fb_addr=(99*640)+149=63509; done once at E+2503.
- Transparency:
  - Stimulus: ROM all 0 except addr 0 = 7 and addr 2499 = 9.
  - Response: exactly 2 writes, at fb_addr 32100 and 63509.
- Clipping:
  - Stimulus: x0=620, y0=470.
  - Response: only cols 0..19 and rows 0..9 written (200 writes); no fb_addr >= 307200; done still pulses.
- Start while busy:
  - Stimulus: second start pulse at E+100.
  - Response: ignored; exactly one done; busy continuous for 2503 cycles.
- Reset mid-blit:
  - Stimulus: resetn low at E+1000.
  - Response: fb_wEn=0, busy=0 asynchronously.
  - Follow-up: next start runs a complete, correct blit.
- Mirror (SPRITE_BLITTER_MIRROR_EN defined):
  - Stimulus: mirror=1, x0=0, y0=0.
  - Response: fb_addr 0 receives ROM addr 49; fb_addr 49 receives ROM addr 0.
